// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with early operand-forward select and load-use detection.
// Latency: 1 cycle ID->EX; id_stall and forward selects are computed combinationally in ID.
// Backpressure: hold freezes all state; a load-use hazard stalls IF/ID and injects one bubble.
//
// Ports:
//   clk, rst_n                      core clock, asynchronous active-low reset
//   id_*                            decoded instruction payload/control presented by ID
//   mem_rd, mem_regwrite            destination of the instruction currently in MEM
//   flush, hold                     kill the instruction entering EX / freeze this cycle
//   ex_*                            registered payload, control and forward selects for EX
//   id_stall                        combinational stall request for PC and IF/ID
//   stall_count                     saturating count of load-use bubbles inserted

module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rs1_data,
    input  logic [31:0]      id_rs2_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_immsrc,
    input  logic             id_islui,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,

    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,

    input  logic             flush,
    input  logic             hold,

    output logic             ex_valid,
    output logic             ex_immsrc,
    output logic             ex_islui,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs1_data,
    output logic [31:0]      ex_rs2_data,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [1:0]       ex_forward1,
    output logic [1:0]       ex_forward2,

    output logic             id_stall,
    output logic [CNT_W-1:0] stall_count
);

    // Operand select encodings consumed by the EX mux.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;  // producer will sit in MEM (ALU result)
    localparam logic [1:0] FWD_WB  = 2'b10;  // producer will sit in WB (write data)

    typedef struct packed {
        logic        valid;
        logic        immsrc;
        logic        islui;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  fwd1;
        logic [1:0]  fwd2;
    } ex_reg_t;

    ex_reg_t          ex_q;
    ex_reg_t          ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Producer currently in EX: qualified by valid so a bubble (all zero) never
    // matches, and rd==0 is excluded because x0 is never really written.
    logic ex_prod;
    logic mem_prod;
    assign ex_prod  = ex_q.valid & ex_q.regwrite & (ex_q.rd != 5'd0);
    assign mem_prod = mem_regwrite & (mem_rd != 5'd0);

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    assign ex_hit1  = id_use_rs1 & ex_prod  & (ex_q.rd == id_rs1);
    assign ex_hit2  = id_use_rs2 & ex_prod  & (ex_q.rd == id_rs2);
    assign mem_hit1 = id_use_rs1 & mem_prod & (mem_rd  == id_rs1);
    assign mem_hit2 = id_use_rs2 & mem_prod & (mem_rd  == id_rs2);

    // The EX producer is younger than the MEM one, so its value wins.
    logic [1:0] fwd1_sel, fwd2_sel;
    assign fwd1_sel = ex_hit1 ? FWD_MEM : (mem_hit1 ? FWD_WB : FWD_REG);
    assign fwd2_sel = ex_hit2 ? FWD_MEM : (mem_hit2 ? FWD_WB : FWD_REG);

    // A load in EX cannot be forwarded from MEM next cycle (data not back yet),
    // so the dependent instruction waits one cycle and then picks it up from WB.
    logic load_dep;
    logic load_use;
    assign load_dep = (id_use_rs1 & (ex_q.rd == id_rs1))
                    | (id_use_rs2 & (ex_q.rd == id_rs2));
    assign load_use = id_valid & ex_q.valid & ex_q.memread
                    & (ex_q.rd != 5'd0) & load_dep;

    // Flush and hold both override the stall: flush discards the ID instruction
    // anyway, and hold re-evaluates the hazard once the pipeline moves again.
    assign id_stall = load_use & ~flush & ~hold;

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (hold) begin
            ex_d  = ex_q;
        end else if (flush) begin
            ex_d  = '0;
        end else if (load_use) begin
            ex_d  = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d.valid    = id_valid;
            ex_d.immsrc   = id_immsrc;
            ex_d.islui    = id_islui;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.pc       = id_pc;
            ex_d.rs1_data = id_rs1_data;
            ex_d.rs2_data = id_rs2_data;
            ex_d.imm      = id_imm;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rd       = id_rd;
            ex_d.fwd1     = fwd1_sel;
            ex_d.fwd2     = fwd2_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_immsrc   = ex_q.immsrc;
    assign ex_islui    = ex_q.islui;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_forward1 = ex_q.fwd1;
    assign ex_forward2 = ex_q.fwd2;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for the ID/EX register, forwarding selects and load-use stall.
// Inputs change 1 time unit after each rising edge; outputs are checked there as well.
// Stall counter is built 2 bits wide so saturation is reached after a few hazards.

module tb_id_ex_stage;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [31:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             id_immsrc, id_islui, id_regwrite, id_memread, id_memwrite;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             flush, hold;
    logic             ex_valid, ex_immsrc, ex_islui, ex_regwrite, ex_memread, ex_memwrite;
    logic [31:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [1:0]       ex_forward1, ex_forward2;
    logic             id_stall;
    logic [CNT_W-1:0] stall_count;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_immsrc(id_immsrc), .id_islui(id_islui), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_immsrc(ex_immsrc), .ex_islui(ex_islui),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_forward1(ex_forward1), .ex_forward2(ex_forward2),
        .id_stall(id_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic rw, input logic mr);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    initial begin
        rst_n        = 1'b0;
        set_id(1'b1, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_rs1_data  = 32'h1111_1111;
        id_rs2_data  = 32'h2222_2222;
        id_imm       = 32'h0000_0004;
        id_immsrc    = 1'b0;
        id_islui     = 1'b0;
        id_memwrite  = 1'b0;
        mem_rd       = 5'd0;
        mem_regwrite = 1'b0;
        flush        = 1'b0;
        hold         = 1'b0;

        // Reset state
        #3;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_id_stall", id_stall, 0);
        rst_n = 1'b1;

        // addi x5 then add x6,x5,x7: EX forward on rs1 only
        set_id(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        id_immsrc = 1'b1;
        step();
        chk("cap_valid", ex_valid, 1);
        chk("cap_pc", ex_pc, 32'h100);
        chk("cap_rs1_data", ex_rs1_data, 32'h1111_1111);
        chk("cap_rs2_data", ex_rs2_data, 32'h2222_2222);
        chk("cap_imm", ex_imm, 32'h4);
        chk("cap_rd", ex_rd, 5);
        chk("cap_ctrl", {ex_immsrc, ex_islui, ex_regwrite, ex_memread, ex_memwrite}, 5'b10100);
        id_immsrc = 1'b0;
        set_id(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("exfwd_f1", ex_forward1, 2'b01);
        chk("exfwd_f2", ex_forward2, 2'b00);
        chk("exfwd_rs", {ex_rs1, ex_rs2}, {5'd5, 5'd7});

        // Producer writes x0: no forwarding
        set_id(1'b1, 32'h108, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 32'h10c, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("x0_f1", ex_forward1, 2'b00);
        chk("x0_f2", ex_forward2, 2'b00);

        // MEM-only match -> 10
        mem_rd = 5'd5;
        mem_regwrite = 1'b1;
        set_id(1'b1, 32'h110, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("memfwd_f1", ex_forward1, 2'b10);
        chk("memfwd_f2", ex_forward2, 2'b00);
        // EX and MEM both match -> EX wins
        set_id(1'b1, 32'h114, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("prio_f1", ex_forward1, 2'b01);
        // Both match but rs1 unused -> 00
        set_id(1'b1, 32'h118, 5'd5, 5'd7, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk("nouse_f1", ex_forward1, 2'b00);
        mem_rd = 5'd0;
        mem_regwrite = 1'b0;

        // Load-use: lw x8 then add x9,x8,x8
        set_id(1'b1, 32'h11c, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk("lw_memread", ex_memread, 1);
        set_id(1'b1, 32'h120, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        #0;
        chk("lu_stall", id_stall, 1);
        step();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_bubble_pc", ex_pc, 0);
        chk("lu_count", stall_count, 1);
        mem_rd = 5'd8;
        mem_regwrite = 1'b1;
        #0;
        chk("lu_stall_drop", id_stall, 0);
        step();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_pc", ex_pc, 32'h120);
        chk("lu_add_f1", ex_forward1, 2'b10);
        chk("lu_add_f2", ex_forward2, 2'b10);
        mem_rd = 5'd0;
        mem_regwrite = 1'b0;

        // Flush coincident with load-use
        set_id(1'b1, 32'h124, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 32'h128, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        #0;
        chk("fl_stall", id_stall, 0);
        step();
        chk("fl_bubble_valid", ex_valid, 0);
        chk("fl_bubble_pc", ex_pc, 0);
        chk("fl_count", stall_count, 1);
        flush = 1'b0;

        // Hold during a load-use hazard
        set_id(1'b1, 32'h12c, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 32'h130, 5'd8, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        hold = 1'b1;
        #0;
        chk("hold_stall", id_stall, 0);
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h130 + 32'(4 * i);
            id_rd = 5'(10 + i);
            step();
            chk("hold_pc", ex_pc, 32'h12c);
            chk("hold_rd", ex_rd, 8);
            chk("hold_ctrl", {ex_valid, ex_regwrite, ex_memread}, 3'b111);
            chk("hold_count", stall_count, 1);
        end
        hold = 1'b0;
        id_pc = 32'h130;
        id_rd = 5'd9;
        #0;
        chk("hold_rel_stall", id_stall, 1);
        step();
        chk("hold_rel_bubble", ex_valid, 0);
        chk("hold_rel_count", stall_count, 2);

        // Two more load-use events: 3, then saturated at 3
        for (int k = 0; k < 2; k++) begin
            set_id(1'b1, 32'h200, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
            step();
            set_id(1'b1, 32'h204, 5'd3, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
            #0;
            chk("sat_stall", id_stall, 1);
            step();
            chk("sat_bubble", ex_valid, 0);
        end
        chk("sat_count", stall_count, 3);

        // Reset mid-stall clears everything without a clock edge
        set_id(1'b1, 32'h300, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 32'h304, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        #0;
        chk("rst2_pre_stall", id_stall, 1);
        chk("rst2_pre_pc", ex_pc, 32'h300);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", ex_valid, 0);
        chk("rst2_pc", ex_pc, 0);
        chk("rst2_rd", ex_rd, 0);
        chk("rst2_data", ex_rs1_data | ex_rs2_data | ex_imm, 0);
        chk("rst2_ctrl", {ex_immsrc, ex_islui, ex_regwrite, ex_memread, ex_memwrite}, 0);
        chk("rst2_fwd", {ex_forward1, ex_forward2}, 0);
        chk("rst2_count", stall_count, 0);
        chk("rst2_stall", id_stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures decoded operands and control from ID, and resolves data hazards one cycle early.
- Registers the `forward1`/`forward2` selects consumed by the EX operand-select mux, and detects load-use hazards, stalling IF/ID and injecting a bubble.
- Handles flush (taken branch/jump resolved in EX) and global hold, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall-cycle counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  32 each  decode payload
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices
- `id_use_rs1`, `id_use_rs2`  in  1 each  instruction reads rs1/rs2
- `id_immsrc`, `id_islui`, `id_regwrite`, `id_memread`, `id_memwrite`  in  1 each  decode control
- `mem_rd`  in  5  rd of the instruction currently in MEM
- `mem_regwrite`  in  1  MEM instruction writes a register
- `flush`  in  1  kill the instruction entering EX
- `hold`  in  1  freeze the whole pipeline this cycle
- `ex_valid`, `ex_immsrc`, `ex_islui`, `ex_regwrite`, `ex_memread`, `ex_memwrite`  out  1 each  registered control
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  32 each  registered payload
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  registered indices
- `ex_forward1`, `ex_forward2`  out  2 each  operand select: 00 regfile, 01 MEM ALU result, 10 WB write data; 11 never driven
- `id_stall`  out  1  combinational; hold PC and IF/ID
- `stall_count`  out  `CNT_W`  load-use bubbles inserted, saturating

## Operation
Forward select for operand N (N = 1, 2), computed combinationally in ID from `id_rsN`:
- **01** if `id_use_rsN`, `ex_valid`, `ex_regwrite`, `ex_rd != 0` and `ex_rd == id_rsN`. The producer will be in MEM when the consumer is in EX.
- else **10** if `id_use_rsN`, `mem_regwrite`, `mem_rd != 0` and `mem_rd == id_rsN`. The producer will be in WB.
- else **00**.
- A producer in WB this cycle is covered by the regfile's write-before-read, not by this block.

Load-use and stall:
- `load_use` = `id_valid & ex_valid & ex_memread & ex_rd != 0` and (`id_use_rs1` & `ex_rd == id_rs1` or `id_use_rs2` & `ex_rd == id_rs2`).
- `id_stall = load_use & ~flush & ~hold`.

Register update priority, each rising edge:
1. `hold` = 1: all registers and `stall_count` keep their value.
2. `flush` = 1: load a bubble.
3. `load_use` = 1: load a bubble; `stall_count` += 1, saturating at all-ones.
4. Otherwise capture the ID inputs and the computed selects. `ex_valid = id_valid`.

Bubble contents:
- All `ex_*` fields are 0, including `ex_rd`, both forward selects, and the data fields.
- A bubble never matches in the forward or load-use logic.

## Timing
- Reset: every `ex_*` output and `stall_count` are 0 asynchronously on `rst_n` low. Release is synchronous to `clk`.
- `id_stall` is 0 while in reset, because `ex_valid` is 0.
- ID-to-EX latency is 1 cycle. `ex_forward*` is valid in the same cycle as its `ex_*` payload.
- A load-use hazard costs exactly one bubble:
  - Cycle t: `id_stall` = 1, the bubble is loaded into EX, and the ID instruction is held.
  - Cycle t+1: the load is in MEM and the ID instruction now matches `mem_rd`, so select 10 is captured.
- Simultaneous `flush` and `load_use`: the flush wins, `id_stall` = 0, and the counter does not increment.
- `hold` during a load-use hazard: no state change and `id_stall` = 0. The hazard is re-evaluated after `hold` drops.
- Reset asserted mid-stall clears the bubble and the counter immediately.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run with `ex_*` nonzero. Required: all outputs are 0 before the next clock edge, `stall_count` = 0, and `id_stall` = 0.
- **EX forward:** `addi x5` (`ex_rd` = 5, regwrite) followed by `add x6,x5,x7` in ID (rs1 = 5). Required after the edge: `ex_forward1` = 01 and `ex_forward2` = 00. Repeat with rd = x0: both selects are 00.
- **MEM forward and priority:**
  - `mem_rd` = 5 only: `ex_forward1` = 10.
  - `mem_rd` = 5 and `ex_rd` = 5 together: `ex_forward1` = 01, because the EX match takes priority.
  - `id_use_rs1` = 0 with either match: `ex_forward1` = 00.
- **Load-use:** `lw x8` in EX, `add x9,x8,x8` in ID. Required:
  - `id_stall` = 1 for one cycle.
  - The next EX content is a bubble (`ex_valid` = 0).
  - The following edge captures the add with `ex_forward1` = `ex_forward2` = 10.
  - `stall_count` goes 0 → 1.
- **Flush vs load-use:** load-use condition present and `flush` = 1 in the same cycle. Required: `id_stall` = 0, a bubble is captured, and `stall_count` is unchanged.
- **Hold and saturation:**
  - `hold` = 1 for 3 cycles with changing ID inputs: all `ex_*` outputs are stable.
  - With `CNT_W` = 2, four load-use events leave `stall_count` = 3.
